// File: rtl/pulpino_gpio_pkg.sv
// Shared constants for the PULPino GPIO bank: register byte offsets, pin limit
// and register index helpers.
package pulpino_gpio_pkg;

   localparam int NPINS_MAX = 32;
   localparam int REG_IDX_W = 3;

   localparam logic [4:0] GPIO_DIR      = 5'h00;
   localparam logic [4:0] GPIO_OUT      = 5'h04;
   localparam logic [4:0] GPIO_IN       = 5'h08;
   localparam logic [4:0] GPIO_INTEN    = 5'h0C;
   localparam logic [4:0] GPIO_RISE     = 5'h10;
   localparam logic [4:0] GPIO_FALL     = 5'h14;
   localparam logic [4:0] GPIO_STATUS   = 5'h18;
   localparam logic [4:0] GPIO_DEBOUNCE = 5'h1C;

   function automatic logic [REG_IDX_W-1:0] reg_idx(input logic [4:0] off);
      return off[4:2];
   endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Per-pin input conditioning: 2-flop synchroniser, debounce filter, edge pulses.
// Latency: pad to deb 3 cycles at threshold 0, 3 + threshold otherwise.
// Backpressure: none; free-running every cycle.
module gpio_pin_filter #(
   parameter int DB_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pin,
   input  logic [DB_W-1:0] db_thresh,
   output logic            deb,
   output logic            rise,
   output logic            fall
);

   logic            meta;
   logic            sync;
   logic            deb_q;
   logic [DB_W-1:0] cnt;

   // The >= compare both saturates the counter and lets a lowered threshold
   // take effect on the very next cycle when the count is already past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         deb   <= 1'b0;
         deb_q <= 1'b0;
         cnt   <= '0;
      end else begin
         meta  <= pin;
         sync  <= meta;
         deb_q <= deb;
         if (sync == deb) begin
            cnt <= '0;
         end else if (cnt >= db_thresh) begin
            deb <= sync;
            cnt <= '0;
         end else begin
            cnt <= cnt + DB_W'(1);
         end
      end
   end

   assign rise = deb & ~deb_q;
   assign fall = ~deb & deb_q;

endmodule

// File: rtl/pulpino_gpio_bank.sv
// APB-controlled GPIO bank with debounced inputs and sticky edge interrupts.
// Latency: zero-wait APB, register writes visible on pins one cycle later.
// Backpressure: none; pready is tied high.
module pulpino_gpio_bank
   import pulpino_gpio_pkg::*;
#(
   parameter int NPINS = 32,
   parameter int DB_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [4:0]       paddr,
   input  logic [31:0]      pwdata,
   output logic [31:0]      prdata,
   output logic             pready,
   output logic             pslverr,
   input  logic [NPINS-1:0] gpio_in,
   output logic [NPINS-1:0] gpio_out,
   output logic [NPINS-1:0] gpio_dir,
   output logic             irq_o
);

   logic [NPINS-1:0]     dir_r, out_r, inten_r, rise_r, fall_r, status_r;
   logic [NPINS-1:0]     status_set, status_clr, status_nxt;
   logic [NPINS-1:0]     deb, rise_ev, fall_ev;
   logic [DB_W-1:0]      debounce_r;
   logic [REG_IDX_W-1:0] idx;
   logic                 xfer, addr_err, wr_en, rd_en;
   logic [31:0]          rd_word;

   // Reset gates the access so a transfer caught by reset never commits.
   assign xfer     = psel & penable & ~rst;
   assign addr_err = |paddr[1:0];
   assign idx      = paddr[4:2];
   assign wr_en    = xfer & pwrite & ~addr_err;
   assign rd_en    = xfer & ~addr_err;

   assign pready   = 1'b1;
   assign pslverr  = xfer & addr_err;
   assign gpio_out = out_r;
   assign gpio_dir = dir_r;

   for (genvar i = 0; i < NPINS; i++) begin : g_pin
      gpio_pin_filter #(.DB_W(DB_W)) u_filt (
         .clk       (clk),
         .rst       (rst),
         .pin       (gpio_in[i]),
         .db_thresh (debounce_r),
         .deb       (deb[i]),
         .rise      (rise_ev[i]),
         .fall      (fall_ev[i])
      );
   end

   // New events are ORed in after the W1C mask so a same-cycle set wins.
   always_comb begin
      status_set = inten_r & ((rise_r & rise_ev) | (fall_r & fall_ev));
      status_clr = '0;
      if (wr_en && idx == reg_idx(GPIO_STATUS)) status_clr = pwdata[NPINS-1:0];
      status_nxt = (status_r & ~status_clr) | status_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_r      <= '0;
         out_r      <= '0;
         inten_r    <= '0;
         rise_r     <= '0;
         fall_r     <= '0;
         status_r   <= '0;
         debounce_r <= '0;
         irq_o      <= 1'b0;
      end else begin
         status_r <= status_nxt;
         irq_o    <= |status_r;
         if (wr_en) begin
            case (idx)
               reg_idx(GPIO_DIR):      dir_r      <= pwdata[NPINS-1:0];
               reg_idx(GPIO_OUT):      out_r      <= pwdata[NPINS-1:0];
               reg_idx(GPIO_INTEN):    inten_r    <= pwdata[NPINS-1:0];
               reg_idx(GPIO_RISE):     rise_r     <= pwdata[NPINS-1:0];
               reg_idx(GPIO_FALL):     fall_r     <= pwdata[NPINS-1:0];
               reg_idx(GPIO_DEBOUNCE): debounce_r <= pwdata[DB_W-1:0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_en) begin
         case (idx)
            reg_idx(GPIO_DIR):      rd_word[NPINS-1:0] = dir_r;
            reg_idx(GPIO_OUT):      rd_word[NPINS-1:0] = out_r;
            reg_idx(GPIO_IN):       rd_word[NPINS-1:0] = deb;
            reg_idx(GPIO_INTEN):    rd_word[NPINS-1:0] = inten_r;
            reg_idx(GPIO_RISE):     rd_word[NPINS-1:0] = rise_r;
            reg_idx(GPIO_FALL):     rd_word[NPINS-1:0] = fall_r;
            reg_idx(GPIO_STATUS):   rd_word[NPINS-1:0] = status_r;
            reg_idx(GPIO_DEBOUNCE): rd_word[DB_W-1:0]  = debounce_r;
            default: ;
         endcase
      end
   end

   assign prdata = rd_word;

endmodule

// File: doc/pulpino_gpio_bank.md
# pulpino_gpio_bank

Parametrised GPIO bank for the FPGA SoC top; it extends the fixed 32-bit `gpio_in`/`gpio_out`/`gpio_dir` pin group. Adds:
- configurable pin count;
- an input synchroniser and per-pin debounce filter;
- rising/falling edge interrupt detection with a sticky status register;
- an APB slave register file for software control.

Sits between the SoC peripheral APB bus and the pad-level GPIO ports.

## Interface
- `NPINS`, 32, number of GPIO pins, 1..32
- `DB_W`, 8, debounce counter width in bits
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `psel`  in  1  APB select
- `penable`  in  1  APB enable/access phase
- `pwrite`  in  1  APB write
- `paddr`  in  5  byte address, word aligned; `paddr[4:2]` is the register index
- `pwdata`  in  32  write data
- `prdata`  out  32  read data
- `pready`  out  1  always 1; zero wait states
- `pslverr`  out  1  error on unmapped address
- `gpio_in`  in  NPINS  raw pad inputs, asynchronous
- `gpio_out`  out  NPINS  output values
- `gpio_dir`  out  NPINS  1 = output driver enabled
- `irq_o`  out  1  level interrupt, OR of all pending status bits

## Operation
Register map (32-bit words; bits at and above NPINS read 0 and ignore writes):
- 0x00 DIR, RW
- 0x04 OUT, RW
- 0x08 IN, RO; debounced input value
- 0x0C INTEN, RW
- 0x10 RISE, RW
- 0x14 FALL, RW
- 0x18 STATUS, RW1C
- 0x1C DEBOUNCE, RW; low DB_W bits

APB rules:
- A transfer is the cycle with `psel` & `penable` high. Writes commit at the clock edge ending that cycle.
- `prdata` is combinational from current register state during the access phase, and 0 otherwise.
- All of 0x00..0x1C are mapped, so `pslverr` asserts only if `paddr[1:0]` != 0. On such an error the write is dropped and `prdata` = 0.

Input path, per pin:
- Stage 1: two-flop synchroniser gives `sync`.
- Stage 2: debounce filter. A per-pin counter resets to 0 whenever `sync` equals the accepted value `deb`. Otherwise it increments. When the counter reaches DEBOUNCE, `deb` takes `sync` and the counter clears.
- DEBOUNCE = 0 bypasses the filter: `deb` follows `sync` with one register stage.
- A glitch shorter than the threshold never reaches `deb`.

Edge detection:
- `deb_q` is `deb` delayed one cycle.
- rise = `deb & ~deb_q`; fall = `~deb & deb_q`.
- For each pin, STATUS[i] sets when `INTEN[i] & ((RISE[i] & rise[i]) | (FALL[i] & fall[i]))`.
- STATUS detection runs regardless of DIR, so output pins looped back through the pad also raise events.

Status and interrupt:
- Writing 1 clears a STATUS bit. If a set and a W1C hit the same bit in the same cycle, set wins.
- Clearing INTEN does not clear STATUS.
- `irq_o` = |STATUS, registered.

Pin outputs:
- `gpio_out` = OUT; `gpio_dir` = DIR. Direct from registers, no extra delay.

## Timing
Reset (asynchronous, `rst` high) drives:
- all registers, synchroniser flops, counters, `deb` and `deb_q` to 0;
- DEBOUNCE to 0;
- outputs: `gpio_out` = 0, `gpio_dir` = 0, `irq_o` = 0, `prdata` = 0, `pslverr` = 0.

`pready` stays 1 throughout, including during reset.

Latencies:
- Pad change to IN visible, DEBOUNCE = 0: 3 cycles (2 synchroniser + 1 `deb`).
- Pad change to IN visible, DEBOUNCE = D > 0: 2 + D + 1 cycles, provided the pad is stable throughout.
- `deb` change to STATUS set: 1 cycle. STATUS set to `irq_o` high: 1 cycle.
- APB write to `gpio_out`/`gpio_dir` change: 1 cycle.

Boundary cases:
- The debounce counter saturates at the compare; it never wraps.
- Writing DEBOUNCE mid-count: the new threshold applies from the next cycle. If the count already exceeds the new threshold, `deb` updates on the next cycle.
- Reset asserted mid-transfer aborts the transfer, with no partial write.

## Structure
- Shared package `pulpino_gpio_pkg` holds:
  - register offset constants `GPIO_DIR` .. `GPIO_DEBOUNCE`;
  - the `NPINS` maximum of 32;
  - the register index width.
- One sub-module, `gpio_pin_filter`: synchroniser, debounce counter and edge outputs for one pin, parameterised by `DB_W`. Instantiate it NPINS times with generate.
- The top level holds the APB decode, register file, STATUS logic and irq.

## Test plan
- Reset mid-operation: set OUT = 0xFFFF, DIR = 0xFFFF, assert `rst` asynchronously between clock edges -> `gpio_out`, `gpio_dir` and `irq_o` go to 0 immediately, with no clock edge needed.
- Bypass latency: DEBOUNCE = 0, raise `gpio_in[3]` -> IN reads 0x8 on the third cycle. With INTEN = RISE = 0x8 -> `irq_o` high 2 cycles later.
- Debounce: DEBOUNCE = 5, pulse `gpio_in[0]` high for 4 cycles -> IN stays 0 and no STATUS. Hold it high for 10 cycles -> IN[0] = 1 exactly 8 cycles after the edge.
- Edge modes: RISE = 0x1, FALL = 0x2, INTEN = 0x3, toggle pins 0 and 1 high then low -> STATUS = 0x1 after the rise, 0x3 after the fall.
- W1C collision: a W1C to STATUS bit 0 in the same cycle as a new rise on pin 0 -> bit 0 stays 1. A following W1C with no event -> STATUS = 0 and `irq_o` low one cycle later.
- Width and error: NPINS = 8, write OUT = 0xFFFFFFFF -> reads 0xFF. Access at `paddr` = 0x05 -> `pslverr` = 1, `prdata` = 0, registers unchanged.
